// File: rtl/mem_arbiter_nport.sv
// mem_arbiter_nport: shares one pipelined, multi-cycle main memory between NUM_CLIENTS
// cache controllers. A client either fetches a whole line as a burst of BURST_LEN word
// reads or writes a single word. Arbitration is fixed-priority or round-robin, and a
// granted transaction always runs to completion.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req, wr              per-client request (held until done) and write(1)/line-read(0)
//   addr, wdata          per-client byte address and write data, client k at slice k
//   gnt                  registered one-hot grant
//   rvalid, rdata, rword read word strobe (granted client only), shared data, word index
//   done                 one-cycle completion pulse to the granted client
//   mem_*                memory command/response interface
module mem_arbiter_nport #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned MEM_LATENCY = 4,
  parameter bit          RR_MODE     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [$clog2(BURST_LEN)-1:0]  rword,
  output logic [NUM_CLIENTS-1:0]        done,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_valid
);

  localparam int unsigned WordW = $clog2(BURST_LEN);
  // Byte-offset bits within a line: word index plus the half-word byte bit.
  localparam int unsigned OffW  = WordW + 1;
  localparam int unsigned IdxW  = $clog2(NUM_CLIENTS);
  localparam logic [WordW:0]   BurstCnt = (WordW + 1)'(BURST_LEN);
  localparam logic [WordW-1:0] LastWord = WordW'(BURST_LEN - 1);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || BURST_LEN < 2 || BURST_LEN > 16 ||
      (BURST_LEN & (BURST_LEN - 1)) != 0 || MEM_LATENCY < 1 || ADDR_W <= OffW)
  begin : g_bad_params
    $error("mem_arbiter_nport: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e                   state_q, state_d;
  logic [NUM_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [IdxW-1:0]          last_q, last_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [WordW:0]           iss_cnt_q, iss_cnt_d;
  logic [WordW-1:0]         ret_cnt_q, ret_cnt_d;

  logic                     win_found;
  logic [IdxW-1:0]          win_idx;
  logic [IdxW-1:0]          cand;

  // Winner search. Round-robin starts one past the last grant and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (RR_MODE) cand = IdxW'((32'(last_q) + 1 + i) % NUM_CLIENTS);
      else         cand = IdxW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    addr_d    = addr_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          last_d         = win_idx;
          addr_d         = addr[win_idx*ADDR_W +: ADDR_W];
          iss_cnt_d      = '0;
          ret_cnt_d      = '0;
          state_d        = wr[win_idx] ? StWr : StRd;
        end
      end
      StRd: begin
        // Issue and return counters advance independently.
        if (iss_cnt_q != BurstCnt) iss_cnt_d = iss_cnt_q + 1'b1;
        if (mem_valid) begin
          if (ret_cnt_q == LastWord) begin
            state_d   = StIdle;
            gnt_d     = '0;
            iss_cnt_d = '0;
            ret_cnt_d = '0;
          end else begin
            ret_cnt_d = ret_cnt_q + 1'b1;
          end
        end
      end
      StWr: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= IdxW'(NUM_CLIENTS - 1);  // client 0 wins the first round-robin pick
      addr_q    <= '0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rvalid    = '0;
    rdata     = '0;
    done      = '0;
    unique case (state_q)
      StRd: begin
        if (iss_cnt_q != BurstCnt) begin
          mem_en   = 1'b1;
          // Line-aligned base with word index in place: base + 2*i without an adder.
          mem_addr = {addr_q[ADDR_W-1:OffW], iss_cnt_q[WordW-1:0], 1'b0};
        end
        if (mem_valid) begin
          rvalid = gnt_q;
          rdata  = mem_rdata;
          if (ret_cnt_q == LastWord) done = gnt_q;
        end
      end
      StWr: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata[idx_q*DATA_W +: DATA_W];
        done      = gnt_q;
      end
      default: ;
    endcase
  end

  assign gnt   = gnt_q;
  assign rword = ret_cnt_q;

endmodule

// File: tb/tb_mem_arbiter_nport.sv
module tb_mem_arbiter_nport;
  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int BL  = 4;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT (round-robin) signals
  logic [N-1:0]    req_m, wr_m, gnt_m, rvalid_m, done_m;
  logic [N*AW-1:0] addr_m;
  logic [N*DW-1:0] wdata_m;
  logic [DW-1:0]   rdata_m, mem_wdata_m, mem_rdata_m;
  logic [1:0]      rword_m;
  logic            mem_en_m, mem_wr_m, mem_valid_m;
  logic [AW-1:0]   mem_addr_m;

  // Fixed-priority DUT signals
  logic [N-1:0]    req_f, wr_f, gnt_f, rvalid_f, done_f;
  logic [N*AW-1:0] addr_f;
  logic [N*DW-1:0] wdata_f;
  logic [DW-1:0]   rdata_f, mem_wdata_f, mem_rdata_f;
  logic [1:0]      rword_f;
  logic            mem_en_f, mem_wr_f, mem_valid_f;
  logic [AW-1:0]   mem_addr_f;

  mem_arbiter_nport #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
                      .MEM_LATENCY(LAT), .RR_MODE(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .req(req_m), .wr(wr_m), .addr(addr_m), .wdata(wdata_m),
    .gnt(gnt_m), .rvalid(rvalid_m), .rdata(rdata_m), .rword(rword_m), .done(done_m),
    .mem_en(mem_en_m), .mem_wr(mem_wr_m), .mem_addr(mem_addr_m), .mem_wdata(mem_wdata_m),
    .mem_rdata(mem_rdata_m), .mem_valid(mem_valid_m));

  mem_arbiter_nport #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
                      .MEM_LATENCY(LAT), .RR_MODE(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .req(req_f), .wr(wr_f), .addr(addr_f), .wdata(wdata_f),
    .gnt(gnt_f), .rvalid(rvalid_f), .rdata(rdata_f), .rword(rword_f), .done(done_f),
    .mem_en(mem_en_f), .mem_wr(mem_wr_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f),
    .mem_rdata(mem_rdata_f), .mem_valid(mem_valid_f));

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Fixed-latency memories: a read issued in cycle c returns in cycle c+LAT.
  logic [LAT-1:0] pv_m = '0, pv_f = '0;
  logic [15:0]    pa_m [LAT];
  logic [15:0]    pa_f [LAT];
  always @(posedge clk) begin
    pv_m     <= {pv_m[LAT-2:0], mem_en_m && !mem_wr_m};
    pv_f     <= {pv_f[LAT-2:0], mem_en_f && !mem_wr_f};
    pa_m[0]  <= mem_addr_m;
    pa_f[0]  <= mem_addr_f;
    for (int i = 1; i < LAT; i++) begin
      pa_m[i] <= pa_m[i-1];
      pa_f[i] <= pa_f[i-1];
    end
  end
  assign mem_valid_m = pv_m[LAT-1];
  assign mem_rdata_m = mem_word(pa_m[LAT-1]);
  assign mem_valid_f = pv_f[LAT-1];
  assign mem_rdata_f = mem_word(pa_f[LAT-1]);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference model
  bit          m_busy = 1'b0;
  bit          m_wr;
  int          m_cli, m_t, m_fin = -1;
  int          m_last = N - 1;
  logic [15:0] m_addr;

  // Observations
  int             cnt_rv [N];
  int             cnt_done [N];
  int             n_mv;
  logic [N-1:0]   last_done, prev_gnt = '0;
  logic [N-1:0]   gseq [$];

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] oh, e_gnt, e_rv, e_done;
    logic         e_en, e_wr;
    logic [15:0]  e_addr, base;
    int           j;
    oh = '0; e_gnt = '0; e_rv = '0; e_done = '0; e_en = 1'b0; e_wr = 1'b0;
    e_addr = '0; base = '0; j = -1;
    if (m_busy) begin
      oh[m_cli] = 1'b1;
      e_gnt = oh;
      if (m_wr) begin
        e_en = 1'b1; e_wr = 1'b1; e_addr = m_addr; e_done = oh;
      end else begin
        base = m_addr & ~16'(2 * BL - 1);
        if (m_t < BL) begin
          e_en = 1'b1;
          e_addr = base + 16'(2 * m_t);
        end
        if (m_t >= LAT && m_t < LAT + BL) begin
          e_rv = oh;
          j = m_t - LAT;
        end
        if (m_t == LAT + BL - 1) e_done = oh;
      end
    end
    check("gnt", gnt_m, e_gnt);
    check("mem_en", mem_en_m, e_en);
    check("rvalid", rvalid_m, e_rv);
    check("done", done_m, e_done);
    if (e_en) begin
      check("mem_wr", mem_wr_m, e_wr);
      check("mem_addr", mem_addr_m, e_addr);
    end
    if (m_busy && m_wr) check("mem_wdata", mem_wdata_m, wdata_m[m_cli*DW +: DW]);
    if (j >= 0) begin
      check("rdata", rdata_m, mem_word(base + 16'(2 * j)));
      check("rword", rword_m, j);
    end
    for (int k = 0; k < N; k++) begin
      if (rvalid_m[k]) cnt_rv[k]++;
      if (done_m[k]) cnt_done[k]++;
    end
    if (mem_valid_m) n_mv++;
    if (gnt_m != '0 && prev_gnt == '0) gseq.push_back(gnt_m);
    prev_gnt  = gnt_m;
    last_done = done_m;
  endtask

  task automatic model_step();
    int w;
    m_fin = -1;
    if (m_busy) begin
      if (m_wr || m_t == LAT + BL - 1) begin
        m_busy = 1'b0;
        m_fin  = m_cli;
      end else begin
        m_t++;
      end
    end else begin
      w = pick(req_m, m_last);
      if (w >= 0) begin
        m_busy = 1'b1; m_t = 0; m_cli = w; m_wr = wr_m[w];
        m_addr = addr_m[w*AW +: AW]; m_last = w;
      end
    end
  endtask

  // Check at negedge, advance model, return at posedge+1 for the next drive.
  task automatic step_cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit w, input logic [15:0] a, input logic [15:0] d);
    req_m[k] = 1'b1;
    wr_m[k] = w;
    addr_m[k*AW +: AW] = a;
    wdata_m[k*DW +: DW] = d;
  endtask

  task automatic wait_done(input int k, input int maxc, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step_cycle();
      if (last_done[k]) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * (LAT + BL) && m_busy; i++) step_cycle();
    step_cycle();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin
      cnt_rv[k] = 0;
      cnt_done[k] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, rv1, nf;
    logic [N-1:0] prev_f;
    rst_n = 1'b0;
    req_m = '0; wr_m = '0; addr_m = '0; wdata_m = '0;
    req_f = '0; wr_f = '0; addr_f = '0; wdata_f = '0;
    clear_counts();
    n_mv = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt_m, 0);
    check("rst_mem_en", mem_en_m, 0);
    check("rst_done", done_m, 0);
    check("rst_rvalid", rvalid_m, 0);
    rst_n = 1'b1;

    // Round-robin: two continuous readers alternate, starting with client 0.
    gseq.delete();
    set_req(0, 1'b0, 16'h0200, 16'h0);
    set_req(1, 1'b0, 16'h0400, 16'h0);
    repeat (30) step_cycle();
    check("rr_grant_count", gseq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rr_grant_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'd0, (i % 2 == 0) ? 1 : 2);
    req_m = '0;
    drain();

    // Client 1 line read at 0x0036, dropping req mid-burst.
    clear_counts();
    set_req(1, 1'b0, 16'h0036, 16'h0);
    repeat (3) step_cycle();
    req_m[1] = 1'b0;
    wait_done(1, 20, "drop");
    check("drop_rvalid_cnt", cnt_rv[1], BL);
    check("drop_done_cnt", cnt_done[1], 1);
    check("drop_other_rvalid", cnt_rv[0] + cnt_rv[2], 0);
    step_cycle();

    // Client 0 single-word write.
    clear_counts();
    set_req(0, 1'b1, 16'h0100, 16'hBEEF);
    wait_done(0, 10, "write");
    req_m[0] = 1'b0;
    check("write_done_cnt", cnt_done[0], 1);
    step_cycle();

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_m[k]) begin
          if (!(m_busy && m_cli == k) && $urandom_range(3) == 0)
            set_req(k, $urandom_range(2) == 0, 16'($urandom), 16'($urandom));
        end else if (m_busy && m_cli == k && !m_wr && m_t >= 1 && $urandom_range(15) == 0) begin
          req_m[k] = 1'b0;
        end else if (m_fin == k && $urandom_range(1) == 0) begin
          req_m[k] = 1'b0;
        end
      end
      step_cycle();
    end
    req_m = '0;
    drain();
    repeat (LAT + BL) step_cycle();

    // Reset in the third cycle of a burst.
    clear_counts();
    set_req(1, 1'b0, 16'h1234, 16'h0);
    repeat (3) step_cycle();
    d1 = cnt_done[1];
    rv1 = cnt_rv[1];
    req_m = '0;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", gnt_m, 0);
    check("midrst_mem_en", mem_en_m, 0);
    check("midrst_mem_addr", mem_addr_m, 0);
    check("midrst_rvalid", rvalid_m, 0);
    check("midrst_done", done_m, 0);
    m_busy = 1'b0;
    m_last = N - 1;
    n_mv = 0;
    step_cycle();
    rst_n = 1'b1;
    repeat (10) step_cycle();
    check("midrst_no_done", cnt_done[1], d1);
    check("midrst_no_rvalid", cnt_rv[1], rv1);
    check("midrst_stale_valid_seen", 32'(n_mv != 0), 1);

    // Fixed priority: client 0 always wins against a continuous client 1.
    req_f = 3'b011;
    addr_f[0 +: AW] = 16'h0040;
    addr_f[AW +: AW] = 16'h0080;
    prev_f = '0;
    nf = 0;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      if (gnt_f != '0 && prev_f == '0) begin
        nf++;
        check("fp_grant", gnt_f, 1);
      end
      prev_f = gnt_f;
    end
    check("fp_grant_count_ge4", 32'(nf >= 4), 1);
    req_f = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
